q_row_reader: RTL and testbench

Reads out one row of Q-values from the accelerator's register bank as a serial valid/ready stream for the action-selection stage. A start pulse snapshots all DEPTH words of the bank, so the learner can keep writing the bank while the row drains. The block then emits the words in index order under downstream backpressure and pulses done after the last word is accepted. It sits between the Q-value register bank (writer side) and the policy/argmax logic (consumer side).

---
 rtl/q_reader_pkg.sv | 15 +
 rtl/q_row_reader_argmax_tracker.sv | 67 ++++++
 rtl/q_row_reader.sv | 118 +++++++++++
 tb/tb_q_row_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/q_reader_pkg.sv
// Shared types for the Q-row reader: FSM state encoding and index-width helper.
package q_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index width for a row of the given depth; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/q_row_reader_argmax_tracker.sv
// Running signed maximum over the words of one streamed row; the result is
// committed on the last accepted word so it is visible during the done cycle.
module argmax_tracker
    import q_reader_pkg::*;
#(
    parameter int WL    = 16,
    parameter int DEPTH = 8,
    localparam int IW   = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [WL-1:0] word,
    input  logic [IW-1:0] idx,
    input  logic          accept,
    input  logic          first,
    input  logic          commit,
    output logic [WL-1:0] max_val,
    output logic [IW-1:0] max_idx
);

    logic [WL-1:0] run_val_q, run_val_d;
    logic [IW-1:0] run_idx_q, run_idx_d;
    logic [WL-1:0] max_val_q, max_val_d;
    logic [IW-1:0] max_idx_q, max_idx_d;
    logic [WL-1:0] cand_val;
    logic [IW-1:0] cand_idx;

    always_comb begin
        cand_val  = run_val_q;
        cand_idx  = run_idx_q;
        run_val_d = run_val_q;
        run_idx_d = run_idx_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        // Strictly-greater replacement keeps the lowest index on ties.
        if (first || ($signed(word) > $signed(run_val_q))) begin
            cand_val = word;
            cand_idx = idx;
        end
        if (accept) begin
            run_val_d = cand_val;
            run_idx_d = cand_idx;
        end
        if (accept && commit) begin
            max_val_d = cand_val;
            max_idx_d = cand_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            run_val_q <= '0;
            run_idx_q <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            run_val_q <= run_val_d;
            run_idx_q <= run_idx_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign max_val = max_val_q;
    assign max_idx = max_idx_q;

endmodule

// File: rtl/q_row_reader.sv
// Snapshots a row of Q-values on start and streams it out word by word over
// valid/ready. Optional argmax tracking is enabled by Q_ROW_READER_ARGMAX_EN.
module q_row_reader
    import q_reader_pkg::*;
#(
    parameter int WL    = 16,
    parameter int DEPTH = 8,
    localparam int IW   = idx_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                start,
    input  logic [DEPTH*WL-1:0] bank_in,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WL-1:0]       out_data,
    output logic [IW-1:0]       out_idx,
    output logic                out_last,
    output logic                done,
    output logic [WL-1:0]       max_val,
    output logic [IW-1:0]       max_idx
);

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WL-1:0] snap_q [DEPTH];
    logic [WL-1:0] snap_d [DEPTH];
    logic          sending;
    logic          at_last;
    logic          fire;

    assign sending = (state_q == SEND);
    assign at_last = (idx_q == LAST_IDX);
    assign fire    = sending && out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        snap_d[i] = bank_in[i*WL +: WL];
                    end
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_snap
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    snap_q[gi] <= '0;
                end else begin
                    snap_q[gi] <= snap_d[gi];
                end
            end
        end
    endgenerate

    // Stream outputs are gated so the idle bus reads zero rather than the stale row.
    assign busy      = (state_q != IDLE);
    assign out_valid = sending;
    assign out_data  = sending ? snap_q[idx_q] : '0;
    assign out_idx   = sending ? idx_q : '0;
    assign out_last  = sending && at_last;
    assign done      = (state_q == DONE);

`ifdef Q_ROW_READER_ARGMAX_EN
    argmax_tracker #(
        .WL    (WL),
        .DEPTH (DEPTH)
    ) u_argmax (
        .clk     (clk),
        .rst_b   (rst_b),
        .word    (snap_q[idx_q]),
        .idx     (idx_q),
        .accept  (fire),
        .first   (idx_q == '0),
        .commit  (at_last),
        .max_val (max_val),
        .max_idx (max_idx)
    );
`else
    assign max_val = '0;
    assign max_idx = '0;
`endif

endmodule

// File: tb/tb_q_row_reader.sv
// Directed bench for q_row_reader: streaming, backpressure, snapshot isolation,
// ignored starts, async reset mid-row and argmax (macro Q_ROW_READER_ARGMAX_EN).
module tb_q_row_reader;

    localparam int WL    = 16;
    localparam int DEPTH = 8;
    localparam int IW    = 3;

    logic                clk = 1'b0;
    logic                rst_b;
    logic                start;
    logic [DEPTH*WL-1:0] bank_in;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [WL-1:0]       out_data;
    logic [IW-1:0]       out_idx;
    logic                out_last;
    logic                done;
    logic [WL-1:0]       max_val;
    logic [IW-1:0]       max_idx;

    logic [WL-1:0] vals [DEPTH];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    q_row_reader #(.WL(WL), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .bank_in   (bank_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done),
        .max_val   (max_val),
        .max_idx   (max_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank();
        for (int i = 0; i < DEPTH; i++) bank_in[i*WL +: WL] = vals[i];
    endtask

    task automatic set_tens();
        for (int i = 0; i < DEPTH; i++) vals[i] = WL'((i + 1) * 10);
        load_bank();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy),      32'h0);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_data"},  32'(out_data),  32'h0);
        chk({tag, "_idx"},   32'(out_idx),   32'h0);
        chk({tag, "_last"},  32'(out_last),  32'h0);
        chk({tag, "_done"},  32'(done),      32'h0);
        chk({tag, "_maxv"},  32'(max_val),   32'h0);
        chk({tag, "_maxi"},  32'(max_idx),   32'h0);
    endtask

    // Streams the row in vals with out_ready held high; returns in the done cycle.
    task automatic run_row(input string tag);
        load_bank();
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(out_data), 32'(vals[i]));
            chk($sformatf("%s_idx%0d", tag, i),  32'(out_idx),  32'(i));
            tick();
        end
        chk({tag, "_done"}, 32'(done), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        set_tens();
        #3;
        check_all_zero("reset");
        repeat (2) tick();
        rst_b = 1'b1;
        repeat (2) tick();

        // Basic stream with snapshot overwrite and ignored starts.
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("s1_busy%0d", i),  32'(busy),      32'h1);
            chk($sformatf("s1_valid%0d", i), 32'(out_valid), 32'h1);
            chk($sformatf("s1_data%0d", i),  32'(out_data),  32'((i + 1) * 10));
            chk($sformatf("s1_idx%0d", i),   32'(out_idx),   32'(i));
            chk($sformatf("s1_last%0d", i),  32'(out_last),  32'(i == DEPTH - 1));
            chk($sformatf("s1_done%0d", i),  32'(done),      32'h0);
            $display("row1 word idx=%0d data=%0d last=%0b", out_idx, out_data, out_last);
            if (i == 0) bank_in = '1;
            if (i == 3) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("s1_done", 32'(done), 32'h1);
        chk("s1_done_busy", 32'(busy), 32'h1);
        chk("s1_done_valid", 32'(out_valid), 32'h0);
`ifdef Q_ROW_READER_ARGMAX_EN
        chk("s1_maxv", 32'(max_val), 32'd80);
        chk("s1_maxi", 32'(max_idx), 32'd7);
`else
        chk("s1_maxv", 32'(max_val), 32'd0);
        chk("s1_maxi", 32'(max_idx), 32'd0);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_idle_busy", 32'(busy), 32'h0);
        chk("s1_idle_done", 32'(done), 32'h0);
        tick();
        chk("s1_norestart_busy",  32'(busy),      32'h0);
        chk("s1_norestart_valid", 32'(out_valid), 32'h0);

        // Backpressure on idx 2: done must land exactly 3 cycles later.
        set_tens();
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("bp_data%0d", i), 32'(out_data), 32'((i + 1) * 10));
            chk($sformatf("bp_idx%0d", i),  32'(out_idx),  32'(i));
            chk($sformatf("bp_done%0d", i), 32'(done),     32'h0);
            $display("row2 word idx=%0d data=%0d", out_idx, out_data);
            if (i == 2) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk($sformatf("bp_hold_data%0d", k),  32'(out_data),  32'd30);
                    chk($sformatf("bp_hold_idx%0d", k),   32'(out_idx),   32'd2);
                    chk($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'h1);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        chk("bp_done", 32'(done), 32'h1);
        tick();
        chk("bp_idle", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of a row.
        set_tens();
        pulse_start();
        repeat (4) tick();
        chk("ar_idx_pre", 32'(out_idx), 32'd4);
        chk("ar_data_pre", 32'(out_data), 32'd50);
        #2;
        rst_b = 1'b0;
        #1;
        check_all_zero("ar");
        $display("async reset asserted mid-row");
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (3) tick();
        chk("ar_stay_busy",  32'(busy),      32'h0);
        chk("ar_stay_valid", 32'(out_valid), 32'h0);

        // Argmax rows: tie to lowest index, then all-negative.
        vals = '{16'hFFFB, 16'd7, 16'd3, 16'd7, 16'hFF9C, 16'd0, 16'd2, 16'd1};
        run_row("am1");
`ifdef Q_ROW_READER_ARGMAX_EN
        chk("am1_maxv", 32'(max_val), 32'd7);
        chk("am1_maxi", 32'(max_idx), 32'd1);
`else
        chk("am1_maxv", 32'(max_val), 32'd0);
        chk("am1_maxi", 32'(max_idx), 32'd0);
`endif
        $display("argmax row1 max_val=%0d max_idx=%0d", $signed(max_val), max_idx);
        tick();
        for (int i = 0; i < DEPTH; i++) vals[i] = WL'(i - 8);
        run_row("am2");
        tick();
        tick();
`ifdef Q_ROW_READER_ARGMAX_EN
        chk("am2_maxv", 32'(max_val), 32'h0000FFFF);
        chk("am2_maxi", 32'(max_idx), 32'd7);
`else
        chk("am2_maxv", 32'(max_val), 32'd0);
        chk("am2_maxi", 32'(max_idx), 32'd0);
`endif
        $display("argmax row2 max_val=%0d max_idx=%0d", $signed(max_val), max_idx);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
